uart_tx_frame: RTL
==================

Name: uart_tx_frame

Overview:
- UART transmitter. It is the transmit-side counterpart of the RX chain (sampler, parity check, stop check) and uses the same oversampled clock, so one prescale value drives both directions.
- Accepts one parallel word per handshake and serialises it LSB-first on tx_out: start bit, DATA_WIDTH data bits, optional parity bit, stop bit.
- Each bit lasts exactly prescale clock cycles.

Parameters:
- DATA_WIDTH, 8: data bits per frame.
- PRESCALE_WIDTH, 6: width of the prescale input and the internal bit-period counter.

Ports:
- clk_based_on_prescale  input  1  oversampled clock (prescale x baud).
- asy_reset  input  1  asynchronous reset, active-low.
- p_data  input  DATA_WIDTH  word to transmit.
- data_valid  input  1  request to send p_data.
- parity_enable  input  1  1 = insert a parity bit.
- parity_type  input  1  0 = even, 1 = odd.
- prescale  input  PRESCALE_WIDTH  cycles per bit; supported values 8, 16, 32.
- tx_out  output  1  serial line, idle high.
- busy  output  1  frame in progress; requests are ignored while high.

Behaviour:
- Reset (asy_reset low, asynchronous):
  - tx_out = 1, busy = 0, state = IDLE.
  - Bit counter and bit-period counter cleared.
  - Takes effect immediately, including mid-frame. The line returns high with no stop bit and no partial completion.
- All outputs are registered. tx_out is driven from a register, never combinationally from the state.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_out = 1, busy = 0.
  - On an edge with data_valid = 1, latch p_data, parity_enable, parity_type and prescale into shadow registers, then go to START.
  - After that edge: tx_out = 0, busy = 1.
  - Input changes after acceptance have no effect on the frame in flight.
- Bit timing:
  - A period counter runs 0..P-1, where P is the latched prescale.
  - The state/bit advances on the edge where the counter equals P-1.
  - Latched prescale = 0 is treated as 1. Other unsupported values are used as-is.
- START: tx_out = 0 for P cycles, then go to DATA with bit index 0.
- DATA:
  - tx_out = data[index], LSB first.
  - After bit DATA_WIDTH-1, go to PARITY if parity is enabled, otherwise to STOP.
- PARITY:
  - tx_out = XOR of the latched data for even parity; the inverse of that XOR for odd parity.
  - Lasts P cycles, then go to STOP.
- STOP:
  - tx_out = 1 for P cycles, then go to IDLE and drop busy on the same edge.
  - At least one further IDLE cycle (line high, busy = 0) always separates frames.
- data_valid while busy = 1: ignored and not queued. The requester must hold or re-issue it after busy falls.
- Frame length in cycles = (2 + DATA_WIDTH + parity_enable + extra_stop) * P, where extra_stop is 0 unless UART_TX_TWO_STOP_EN is defined.
- busy is high for exactly that many cycles.
- data_valid held high continuously sends back-to-back frames, each separated by exactly one idle cycle.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined:
  - Extra input stop_bits (1 bit): 0 = one stop bit, 1 = two stop bits.
  - stop_bits is latched at acceptance.
  - In STOP, a second P-cycle high period is sent before IDLE when the latched value is 1; extra_stop equals the latched value.
- Not defined:
  - The stop_bits port is absent.
  - One stop bit always; extra_stop = 0.

Test Plan:
- prescale=8, parity_enable=1, parity_type=0, p_data=0xA5, one-cycle data_valid:
  - tx_out over 88 cycles, in 8-cycle bits: 0,1,0,1,0,0,1,0,1,0(parity),1(stop).
  - busy high for exactly 88 cycles, then low.
- prescale=16, parity_enable=1, p_data=0x01:
  - parity_type=1 gives a parity bit of 0.
  - parity_type=0 gives a parity bit of 1.
  - Frame is 176 cycles.
- prescale=8, parity_enable=0, data_valid held high with p_data=0x3C, 0xC3:
  - Two 80-cycle frames separated by exactly 1 idle-high cycle.
  - p_data changed mid-frame does not alter the current frame.
- Assert asy_reset low in the middle of data bit 3:
  - tx_out=1 and busy=0 immediately, asynchronously.
  - After release with no data_valid, the line stays high.
- data_valid pulsed during START and during STOP of an active frame:
  - Ignored; only one frame is sent.
  - busy deasserts after 88 cycles (prescale=8, parity enabled).
- With UART_TX_TWO_STOP_EN, stop_bits=1, prescale=8, parity disabled, p_data=0xFF:
  - Frame is 88 cycles; the final 16 cycles are high.
  - busy falls at cycle 88.

Source files
------------

// File: rtl/uart_tx_frame_if.sv
// -----------------------------------------------------------------------------
// uart_tx_frame_if
// Purpose : bundles the parallel-word request side and the serial/status side
//           of the UART transmitter.
// Signals : p_data, data_valid, parity_enable, parity_type, prescale
//           (requester -> transmitter); tx_out, busy (transmitter -> requester).
//           stop_bits (requester -> transmitter) exists only when
//           UART_TX_TWO_STOP_EN is defined.
// Modports: master = requester side, slave = transmitter side.
// -----------------------------------------------------------------------------
interface uart_tx_frame_if #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
);
    logic [DATA_WIDTH-1:0]     p_data;
    logic                      data_valid;
    logic                      parity_enable;
    logic                      parity_type;
    logic [PRESCALE_WIDTH-1:0] prescale;
`ifdef UART_TX_TWO_STOP_EN
    logic                      stop_bits;
`endif
    logic                      tx_out;
    logic                      busy;

    modport master (
        output p_data,
        output data_valid,
        output parity_enable,
        output parity_type,
        output prescale,
`ifdef UART_TX_TWO_STOP_EN
        output stop_bits,
`endif
        input  tx_out,
        input  busy
    );

    modport slave (
        input  p_data,
        input  data_valid,
        input  parity_enable,
        input  parity_type,
        input  prescale,
`ifdef UART_TX_TWO_STOP_EN
        input  stop_bits,
`endif
        output tx_out,
        output busy
    );
endinterface

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
// Purpose : UART transmitter. Accepts one word per data_valid handshake while
//           idle and serialises it LSB-first: start, DATA_WIDTH data bits,
//           optional parity, stop. Each bit lasts prescale clock cycles.
// Ports   : clk_based_on_prescale - oversampled clock (prescale x baud)
//           asy_reset             - asynchronous reset, active-low
//           bus (slave modport)   - p_data, data_valid, parity_enable,
//                                   parity_type, prescale in; tx_out, busy out
// Options : UART_TX_TWO_STOP_EN - adds bus.stop_bits; when the latched value
//           is 1 a second stop period is sent.
// -----------------------------------------------------------------------------
module uart_tx_frame #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic          clk_based_on_prescale,
    input  logic          asy_reset,
    uart_tx_frame_if.slave bus
);
    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                    r_state,      w_state_next;
    logic [DATA_WIDTH-1:0]     r_data,       w_data_next;
    logic                      r_par_en,     w_par_en_next;
    logic                      r_par_type,   w_par_type_next;
    logic [PRESCALE_WIDTH-1:0] r_prescale,   w_prescale_next;
    logic [PRESCALE_WIDTH-1:0] r_cnt,        w_cnt_next;
    logic [IDX_W-1:0]          r_idx,        w_idx_next;
    logic                      r_tx,         w_tx_next;
    logic                      r_busy,       w_busy_next;
`ifdef UART_TX_TWO_STOP_EN
    logic                      r_stop2,      w_stop2_next;
    logic                      r_stop_second, w_stop_second_next;
`endif

    logic [PRESCALE_WIDTH-1:0] w_last;
    logic [IDX_W-1:0]          w_idx_inc;
    logic                      w_parity;

    // A latched prescale of 0 behaves as 1: the period counter never leaves 0.
    assign w_last    = (r_prescale == '0) ? '0 : r_prescale - 1'b1;
    assign w_idx_inc = r_idx + 1'b1;
    assign w_parity  = (^r_data) ^ r_par_type;

    always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
        if (!asy_reset) begin
            r_state       <= StIdle;
            r_data        <= '0;
            r_par_en      <= 1'b0;
            r_par_type    <= 1'b0;
            r_prescale    <= '0;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_tx          <= 1'b1;
            r_busy        <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            r_stop2       <= 1'b0;
            r_stop_second <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_next;
            r_data        <= w_data_next;
            r_par_en      <= w_par_en_next;
            r_par_type    <= w_par_type_next;
            r_prescale    <= w_prescale_next;
            r_cnt         <= w_cnt_next;
            r_idx         <= w_idx_next;
            r_tx          <= w_tx_next;
            r_busy        <= w_busy_next;
`ifdef UART_TX_TWO_STOP_EN
            r_stop2       <= w_stop2_next;
            r_stop_second <= w_stop_second_next;
`endif
        end
    end

    // Next-state logic also produces the next registered tx/busy values, so the
    // outputs change on the same edge as the state.
    always_comb begin
        w_state_next       = r_state;
        w_data_next        = r_data;
        w_par_en_next      = r_par_en;
        w_par_type_next    = r_par_type;
        w_prescale_next    = r_prescale;
        w_cnt_next         = r_cnt;
        w_idx_next         = r_idx;
        w_tx_next          = r_tx;
        w_busy_next        = r_busy;
`ifdef UART_TX_TWO_STOP_EN
        w_stop2_next       = r_stop2;
        w_stop_second_next = r_stop_second;
`endif

        if (r_state == StIdle) begin
            w_tx_next   = 1'b1;
            w_busy_next = 1'b0;
            w_cnt_next  = '0;
            w_idx_next  = '0;
            if (bus.data_valid) begin
                w_data_next     = bus.p_data;
                w_par_en_next   = bus.parity_enable;
                w_par_type_next = bus.parity_type;
                w_prescale_next = bus.prescale;
`ifdef UART_TX_TWO_STOP_EN
                w_stop2_next       = bus.stop_bits;
                w_stop_second_next = 1'b0;
`endif
                w_state_next    = StStart;
                w_tx_next       = 1'b0;
                w_busy_next     = 1'b1;
            end
        end else if (r_cnt != w_last) begin
            w_cnt_next = r_cnt + 1'b1;
        end else begin
            w_cnt_next = '0;
            unique case (r_state)
                StStart: begin
                    w_state_next = StData;
                    w_idx_next   = '0;
                    w_tx_next    = r_data[0];
                end
                StData: begin
                    if (r_idx == LAST_IDX) begin
                        if (r_par_en) begin
                            w_state_next = StParity;
                            w_tx_next    = w_parity;
                        end else begin
                            w_state_next = StStop;
                            w_tx_next    = 1'b1;
                        end
                    end else begin
                        w_idx_next = w_idx_inc;
                        w_tx_next  = r_data[w_idx_inc];
                    end
                end
                StParity: begin
                    w_state_next = StStop;
                    w_tx_next    = 1'b1;
                end
                StStop: begin
`ifdef UART_TX_TWO_STOP_EN
                    if (r_stop2 && !r_stop_second) begin
                        // Stay in STOP for one more bit period, line held high.
                        w_stop_second_next = 1'b1;
                    end else begin
                        w_stop_second_next = 1'b0;
                        w_state_next       = StIdle;
                        w_busy_next        = 1'b0;
                        w_tx_next          = 1'b1;
                    end
`else
                    w_state_next = StIdle;
                    w_busy_next  = 1'b0;
                    w_tx_next    = 1'b1;
`endif
                end
                default: begin
                    w_state_next = StIdle;
                    w_busy_next  = 1'b0;
                    w_tx_next    = 1'b1;
                end
            endcase
        end
    end

    assign bus.tx_out = r_tx;
    assign bus.busy   = r_busy;
endmodule
